fcore_decode_stage: RTL
=======================

// Module: fcore_decode_stage
// PURPOSE
// Parametrised instruction decode stage for fCore. Sits between program-memory fetch and the execution units.
// Accepts instruction words over a valid/ready stream and fuses two-word LDC (opcode + constant) into one decoded op.
// Emits register-addressed decoded ops through a registered output with a one-entry skid buffer; tracks STOP/halt and illegal opcodes.
// PARAMETERS
// INSTRUCTION_WIDTH  32  width of instruction and constant words
// OPCODE_WIDTH       5   opcode field width; 6 reserves room for ISA growth
// REG_ADDR_WIDTH     4   register address field width (op_a, op_b, dest)
// N_OPCODES          20  opcodes >= N_OPCODES are illegal (NOP=0..POPCNT=19)
// PORTS
// clock         in   1     system clock
// reset         in   1     asynchronous, active-low reset
// start         in   1     pulse: leave HALTED, clear error
// in_data       in   IW    instruction or LDC constant word
// in_valid      in   1     in_data valid
// in_ready      out  1     stage accepts in_data
// dec_opcode    out  OW    decoded opcode (NOP when illegal)
// dec_op_a      out  RAW   operand A address
// dec_op_b      out  RAW   operand B address (0 for single-operand ops)
// dec_dest      out  RAW   destination address
// dec_constant  out  IW    LDC constant, 0 otherwise
// dec_writes    out  1     op writes dest (0 for NOP, STOP, illegal)
// dec_is_branch out  1     opcode in BGT..BNE (8..11)
// dec_valid     out  1     decoded op valid
// dec_ready     in   1     downstream accepts decoded op
// halted        out  1     core halted (after STOP or reset)
// illegal_error out  1     sticky: illegal opcode seen
// BEHAVIOUR
// - Fields: opcode=[OW-1:0], op_a=[OW+:RAW], op_b=[OW+RAW+:RAW], dest=[OW+2RAW+:RAW]; OW+3*RAW<=IW, elaboration error otherwise.
// - Transfer on valid&ready, both sides; in_valid must not depend on in_ready.
// - Reset: all dec_* outputs 0, dec_valid=0, in_ready=0, halted=1, illegal_error=0, state HALTED, skid empty.
// - FSM: HALTED -(start)-> RUN; RUN -(LDC word accepted)-> LDC_CONST; LDC_CONST -(constant word accepted)-> RUN;
//   RUN -(STOP accepted)-> HALTED. start in RUN/LDC_CONST ignored.
// - in_ready = (state!=HALTED) & skid empty. Halted=1 only in HALTED.
// - Latency: decoded op appears on dec_valid the cycle after its last word is accepted (single-word: 1; LDC: 1 after constant).
// - Full throughput: 1 op/cycle while dec_ready=1; LDC costs 2 input cycles.
// - Back-pressure: op completing while output held and dec_ready=0 goes to skid; in_ready drops next cycle;
//   skid drains to output on next dec_ready; ordering preserved, no loss, no duplication.
// - Output stable (all dec_*) while dec_valid=1 & dec_ready=0.
// - Single-operand ops ITF,FTI,LDR,LNOT,REC,POPCNT: dec_op_b=0. LDC: op_a=op_b=0, dest from first word.
// - STOP: emitted as decoded op (dec_writes=0), then HALTED; words after STOP are not accepted.
// - Illegal opcode: emitted as NOP with same fields zeroed, dec_writes=0; illegal_error set next cycle, cleared by start.
// - start and illegal detection same cycle: illegal wins (error stays set).
// - Reset mid-LDC or mid-stall: pending op and skid discarded, back to reset values.
// TESTING
// - start, in_data=0x6421 (ADD a=1 b=2 d=3) -> next cycle dec_valid=1, opcode=1, a=1, b=2, dest=3, dec_writes=1.
// - LDC d=5 then constant 0x3F800000 -> one dec op: opcode=6, dest=5, constant=0x3F800000; no output between words.
// - stream 4 ADDs, dec_ready low 3 cycles mid-stream -> in_ready drops, all 4 ops out in order, none duplicated.
// - STOP (0x0C) followed by ADD valid -> STOP emitted, halted=1, in_ready=0; ADD accepted only after start pulse.
// - opcode 25 -> dec_opcode=0, dec_writes=0, illegal_error=1 until start; FTI word: dec_op_b=0 regardless of field.
// - reset asserted after LDC first word -> all outputs reset values; after start, next word decoded as fresh instruction.

Source files
------------

// File: rtl/fcore_decode_stage.sv
// fCore instruction decode stage: valid/ready in, fuses LDC opcode+constant,
// registered decoded-op output backed by a one-entry skid buffer.
module fcore_decode_stage #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int OPCODE_WIDTH      = 5,
  parameter int REG_ADDR_WIDTH    = 4,
  parameter int N_OPCODES         = 20
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [OPCODE_WIDTH-1:0]      dec_opcode,
  output logic [REG_ADDR_WIDTH-1:0]    dec_op_a,
  output logic [REG_ADDR_WIDTH-1:0]    dec_op_b,
  output logic [REG_ADDR_WIDTH-1:0]    dec_dest,
  output logic [INSTRUCTION_WIDTH-1:0] dec_constant,
  output logic                         dec_writes,
  output logic                         dec_is_branch,
  output logic                         dec_valid,
  input  logic                         dec_ready,
  output logic                         halted,
  output logic                         illegal_error
);
  localparam int IW  = INSTRUCTION_WIDTH;
  localparam int OW  = OPCODE_WIDTH;
  localparam int RAW = REG_ADDR_WIDTH;

  if (OW + 3*RAW > IW) begin : g_bad_fields
    $error("fcore_decode_stage: opcode and register fields exceed INSTRUCTION_WIDTH");
  end

  localparam logic [OW-1:0] OP_NOP    = OW'(0);
  localparam logic [OW-1:0] OP_ITF    = OW'(4);
  localparam logic [OW-1:0] OP_FTI    = OW'(5);
  localparam logic [OW-1:0] OP_LDC    = OW'(6);
  localparam logic [OW-1:0] OP_LDR    = OW'(7);
  localparam logic [OW-1:0] OP_BGT    = OW'(8);
  localparam logic [OW-1:0] OP_BNE    = OW'(11);
  localparam logic [OW-1:0] OP_STOP   = OW'(12);
  localparam logic [OW-1:0] OP_LNOT   = OW'(15);
  localparam logic [OW-1:0] OP_REC    = OW'(18);
  localparam logic [OW-1:0] OP_POPCNT = OW'(19);

  typedef struct packed {
    logic [OW-1:0]  opcode;
    logic [RAW-1:0] op_a;
    logic [RAW-1:0] op_b;
    logic [RAW-1:0] dest;
    logic [IW-1:0]  constant;
    logic           writes;
    logic           is_branch;
  } dec_t;

  typedef enum logic [1:0] {HALTED, RUN, LDC_CONST} state_t;

  state_t         state, state_nxt;
  logic [RAW-1:0] ldc_dest;
  dec_t           cur, out_q, skid_q;
  logic           out_vld, skid_vld, err_q;
  logic           fire, complete, illegal;

  wire [OW-1:0]  word_op = in_data[OW-1:0];
  wire [RAW-1:0] word_a  = in_data[OW +: RAW];
  wire [RAW-1:0] word_b  = in_data[OW+RAW +: RAW];
  wire [RAW-1:0] word_d  = in_data[OW+2*RAW +: RAW];

  assign in_ready = (state != HALTED) && !skid_vld;
  assign fire     = in_valid && in_ready;

  // Decode of the word currently presented; complete marks the last word of an op.
  always_comb begin
    cur      = '0;
    illegal  = 1'b0;
    complete = 1'b0;
    if (state == LDC_CONST) begin
      cur.opcode   = OP_LDC;
      cur.dest     = ldc_dest;
      cur.constant = in_data;
      cur.writes   = 1'b1;
      complete     = fire;
    end else begin
      if (32'(word_op) >= N_OPCODES) begin
        illegal = 1'b1;
      end else begin
        cur.opcode    = word_op;
        cur.op_a      = word_a;
        cur.op_b      = word_b;
        cur.dest      = word_d;
        cur.writes    = (word_op != OP_NOP) && (word_op != OP_STOP);
        cur.is_branch = (word_op >= OP_BGT) && (word_op <= OP_BNE);
        if (word_op inside {OP_ITF, OP_FTI, OP_LDR, OP_LNOT, OP_REC, OP_POPCNT})
          cur.op_b = '0;
      end
      complete = fire && (word_op != OP_LDC);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HALTED:    if (start) state_nxt = RUN;
      RUN:       if (fire) begin
                   if (word_op == OP_LDC)       state_nxt = LDC_CONST;
                   else if (word_op == OP_STOP) state_nxt = HALTED;
                 end
      LDC_CONST: if (fire) state_nxt = RUN;
      default:   state_nxt = HALTED;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= HALTED;
      ldc_dest <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fire && state == RUN && word_op == OP_LDC) ldc_dest <= word_d;
      // A fresh illegal opcode outranks a concurrent start.
      if (fire && illegal) err_q <= 1'b1;
      else if (start)      err_q <= 1'b0;
    end
  end

  // Output register refills from skid first; a completing op lands in skid only when output is stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else if (!out_vld || dec_ready) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= complete;
        if (complete) out_q <= cur;
      end
    end else if (complete) begin
      skid_q   <= cur;
      skid_vld <= 1'b1;
    end
  end

  assign dec_opcode    = out_q.opcode;
  assign dec_op_a      = out_q.op_a;
  assign dec_op_b      = out_q.op_b;
  assign dec_dest      = out_q.dest;
  assign dec_constant  = out_q.constant;
  assign dec_writes    = out_q.writes;
  assign dec_is_branch = out_q.is_branch;
  assign dec_valid     = out_vld;
  assign halted        = (state == HALTED);
  assign illegal_error = err_q;
endmodule
